// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK transmit scheduler: state encoding and symbol length helper.
package bpsk_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WARM = 2'd1;
  localparam logic [1:0] PRE  = 2'd2;
  localparam logic [1:0] DATA = 2'd3;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StWarm = WARM,
    StPre  = PRE,
    StData = DATA
  } state_e;

  function automatic int unsigned samples_per_sym(input int unsigned num,
                                                  input int unsigned sym_periods);
    return 4 * num * sym_periods;
  endfunction

endpackage

// File: rtl/symbol_timer.sv
// Sample/period counter pair marking the first and final cycle of every BPSK symbol.
module symbol_timer
  import bpsk_pkg::*;
#(
  parameter int unsigned NUM         = 2,
  parameter int unsigned SYM_PERIODS = 4
) (
  input  logic clk_sig,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sym_start,
  output logic o_sym_end
);

  localparam int unsigned PerLen = 4 * NUM;
  localparam int unsigned SW     = $clog2(PerLen);
  localparam int unsigned PW     = (SYM_PERIODS > 1) ? $clog2(SYM_PERIODS) : 1;
  localparam logic [SW-1:0] SampMax = SW'(PerLen - 1);
  localparam logic [PW-1:0] PerMax  = PW'(SYM_PERIODS - 1);

  logic [SW-1:0] r_samp;
  logic [PW-1:0] r_per;
  logic          w_samp_wrap;
  logic          w_per_wrap;

  assign w_samp_wrap = (r_samp == SampMax);
  assign w_per_wrap  = (r_per == PerMax);

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      r_samp <= '0;
      r_per  <= '0;
    end else if (i_clr) begin
      r_samp <= '0;
      r_per  <= '0;
    end else if (i_en) begin
      if (w_samp_wrap) begin
        r_samp <= '0;
        r_per  <= w_per_wrap ? '0 : r_per + 1'b1;
      end else begin
        r_samp <= r_samp + 1'b1;
      end
    end
  end

  assign o_sym_start = i_en && (r_samp == '0) && (r_per == '0);
  assign o_sym_end   = i_en && w_samp_wrap && w_per_wrap;

endmodule

// File: rtl/bpsk_tx_scheduler.sv
// BPSK frame sequencer: gates the carrier through its reset and emits +/- carrier per bit.
// Define BPSK_PREAMBLE_EN to prefix each frame with PRE_SYMS all-ones symbols.
module bpsk_tx_scheduler
  import bpsk_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NUM         = 2,
  parameter int unsigned SYM_PERIODS = 4,
  parameter int unsigned CAR_LAT     = 2,
  parameter int unsigned PRE_SYMS    = 8
) (
  input  logic             clk_sig,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_data,
  input  logic             bit_last,
  output logic             bit_ready,
  output logic             carrier_rst_n,
  input  logic [WIDTH-1:0] carrier_sig,
  output logic [WIDTH-1:0] mod_sig,
  output logic             mod_valid,
  output logic             sym_strobe,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned WW = (CAR_LAT > 1) ? $clog2(CAR_LAT) : 1;
  localparam logic [WW-1:0]    WarmMax = WW'(CAR_LAT - 1);
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH - 1) {1'b0}}};
  localparam logic [WIDTH-1:0] MostPos = {1'b0, {(WIDTH - 1) {1'b1}}};

  if (SYM_PERIODS < 1 || CAR_LAT < 1 || PRE_SYMS < 1 ||
      samples_per_sym(NUM, SYM_PERIODS) == 0) begin : g_param_check
    $error("bpsk_tx_scheduler: illegal parameter value");
  end

  state_e           r_state, w_state_d;
  logic             r_bit, w_bit_d;
  logic             r_last, w_last_d;
  logic [WW-1:0]    r_warm_cnt, w_warm_cnt_d;
  logic             w_ready;
  logic             w_underrun_d;
  logic             w_tx_en;
  logic             w_tx_bit;
  logic             w_sym_start;
  logic             w_sym_end;
  logic [WIDTH-1:0] w_mod_d;
  logic [WIDTH-1:0] r_mod_sig;
  logic             r_mod_valid;
  logic             r_sym_strobe;
  logic             r_underrun;

`ifdef BPSK_PREAMBLE_EN
  localparam int unsigned PCW = (PRE_SYMS > 1) ? $clog2(PRE_SYMS) : 1;
  localparam logic [PCW-1:0] PreMax = PCW'(PRE_SYMS - 1);
  logic [PCW-1:0] r_pre_cnt, w_pre_cnt_d;
`endif

  assign w_tx_en  = (r_state == StPre) || (r_state == StData);
  assign w_tx_bit = (r_state == StData) ? r_bit : 1'b1;

  symbol_timer #(
    .NUM        (NUM),
    .SYM_PERIODS(SYM_PERIODS)
  ) u_symbol_timer (
    .clk_sig    (clk_sig),
    .rst_n      (rst_n),
    .i_clr      (!w_tx_en),
    .i_en       (w_tx_en),
    .o_sym_start(w_sym_start),
    .o_sym_end  (w_sym_end)
  );

  always_comb begin
    w_state_d    = r_state;
    w_bit_d      = r_bit;
    w_last_d     = r_last;
    w_warm_cnt_d = '0;
    w_underrun_d = 1'b0;
    w_ready      = 1'b0;
`ifdef BPSK_PREAMBLE_EN
    w_pre_cnt_d  = r_pre_cnt;
`endif
    unique case (r_state)
      StIdle: begin
        w_ready = 1'b1;
        if (bit_valid) begin
          w_bit_d   = bit_data;
          w_last_d  = bit_last;
          w_state_d = StWarm;
        end
      end
      StWarm: begin
        w_warm_cnt_d = r_warm_cnt + 1'b1;
        if (r_warm_cnt == WarmMax) begin
          w_warm_cnt_d = '0;
`ifdef BPSK_PREAMBLE_EN
          w_pre_cnt_d  = '0;
          w_state_d    = StPre;
`else
          w_state_d    = StData;
`endif
        end
      end
`ifdef BPSK_PREAMBLE_EN
      StPre: begin
        if (w_sym_end) begin
          if (r_pre_cnt == PreMax) begin
            w_state_d = StData;
          end else begin
            w_pre_cnt_d = r_pre_cnt + 1'b1;
          end
        end
      end
`endif
      StData: begin
        // Next bit is only offered in the final cycle so symbols abut without a gap.
        if (w_sym_end) begin
          if (r_last) begin
            w_state_d = StIdle;
          end else begin
            w_ready = 1'b1;
            if (bit_valid) begin
              w_bit_d  = bit_data;
              w_last_d = bit_last;
            end else begin
              w_underrun_d = 1'b1;
              w_state_d    = StIdle;
            end
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_mod_d = '0;
    if (w_tx_en) begin
      if (w_tx_bit) begin
        w_mod_d = carrier_sig;
      end else if (carrier_sig == MostNeg) begin
        w_mod_d = MostPos;
      end else begin
        w_mod_d = (~carrier_sig) + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_bit        <= 1'b0;
      r_last       <= 1'b0;
      r_warm_cnt   <= '0;
      r_mod_sig    <= '0;
      r_mod_valid  <= 1'b0;
      r_sym_strobe <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_bit        <= w_bit_d;
      r_last       <= w_last_d;
      r_warm_cnt   <= w_warm_cnt_d;
      r_mod_sig    <= w_mod_d;
      r_mod_valid  <= w_tx_en;
      r_sym_strobe <= w_sym_start;
      r_underrun   <= w_underrun_d;
    end
  end

`ifdef BPSK_PREAMBLE_EN
  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= w_pre_cnt_d;
    end
  end
`endif

  // Ready must read 0 while reset is held, before any clock edge.
  assign bit_ready     = w_ready & rst_n;
  assign carrier_rst_n = (r_state != StIdle);
  assign busy          = (r_state != StIdle);
  assign mod_sig       = r_mod_sig;
  assign mod_valid     = r_mod_valid;
  assign sym_strobe    = r_sym_strobe;
  assign underrun      = r_underrun;

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Self-checking bench for bpsk_tx_scheduler: per-cycle frame model plus literal spot checks.
module tb_bpsk_tx_scheduler;

  localparam int W   = 16;
  localparam int NUM = 2;
  localparam int SP  = 4;
  localparam int CL  = 2;
  localparam int PS  = 8;
  localparam int S   = 4 * NUM * SP;
`ifdef BPSK_PREAMBLE_EN
  localparam int P = PS;
`else
  localparam int P = 0;
`endif
  localparam int N = 2048;

  logic         clk_sig = 1'b0;
  logic         rst_n = 1'b0;
  logic         bit_valid = 1'b0;
  logic         bit_data = 1'b0;
  logic         bit_last = 1'b0;
  logic         bit_ready;
  logic         carrier_rst_n;
  logic [W-1:0] carrier_sig = '0;
  logic [W-1:0] mod_sig;
  logic         mod_valid;
  logic         sym_strobe;
  logic         busy;
  logic         underrun;

  bpsk_tx_scheduler #(
    .WIDTH      (W),
    .NUM        (NUM),
    .SYM_PERIODS(SP),
    .CAR_LAT    (CL),
    .PRE_SYMS   (PS)
  ) dut (
    .clk_sig      (clk_sig),
    .rst_n        (rst_n),
    .bit_valid    (bit_valid),
    .bit_data     (bit_data),
    .bit_last     (bit_last),
    .bit_ready    (bit_ready),
    .carrier_rst_n(carrier_rst_n),
    .carrier_sig  (carrier_sig),
    .mod_sig      (mod_sig),
    .mod_valid    (mod_valid),
    .sym_strobe   (sym_strobe),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 clk_sig = ~clk_sig;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus and expectations, indexed by cycle within a phase.
  logic [W-1:0] car[N];
  logic         d_valid[N], d_data[N], d_last[N];
  logic         e_valid[N], e_strobe[N], e_busy[N], e_crst[N], e_ready[N], e_under[N];
  logic [W-1:0] e_sig[N];
  logic         o_valid[N], o_strobe[N], o_under[N], o_crst[N];
  logic [W-1:0] o_sig[N];

  task automatic chk1(input string name, input int c, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, c, act, exp);
    end
  endtask

  task automatic chkw(input string name, input int c, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mod_f(input logic b, input logic [W-1:0] c);
    if (b) return c;
    if (c == 16'h8000) return 16'h7FFF;
    return W'(0) - c;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < N; c++) begin
      car[c]      = ((c % 7) == 3) ? 16'h8000 : W'($urandom);
      d_valid[c]  = 1'b0;
      d_data[c]   = 1'b0;
      d_last[c]   = 1'b0;
      e_valid[c]  = 1'b0;
      e_sig[c]    = '0;
      e_strobe[c] = 1'b0;
      e_busy[c]   = 1'b0;
      e_crst[c]   = 1'b0;
      e_ready[c]  = 1'b1;
      e_under[c]  = 1'b0;
    end
  endtask

  // Frame accepted at cycle a; nsup of nbits bits are offered. Returns first idle cycle after.
  task automatic plan_frame(input int a, input int nbits, input int nsup, input logic [7:0] bits,
                            output int e);
    int d;
    int nsym;
    int h_prev;
    d      = a + 1 + CL;
    nsym   = P + nsup;
    h_prev = a;
    d_valid[a] = 1'b1;
    d_data[a]  = bits[0];
    d_last[a]  = (nbits == 1);
    for (int j = 1; j < nsup; j++) begin
      int h;
      h = d + S * (P + j) - 1;
      for (int c = h_prev + 1; c <= h; c++) begin
        d_valid[c] = 1'b1;
        d_data[c]  = bits[j];
        d_last[c]  = (j == nbits - 1);
      end
      h_prev = h;
    end
    for (int c = a + 1; c < d + S * nsym; c++) begin
      e_busy[c]  = 1'b1;
      e_crst[c]  = 1'b1;
      e_ready[c] = 1'b0;
    end
    for (int j = 0; j < nsup; j++) begin
      if (j != nbits - 1) e_ready[d + S * (P + j + 1) - 1] = 1'b1;
    end
    for (int k = 0; k < S * nsym; k++) begin
      int   s;
      logic b;
      s = k / S;
      b = (s < P) ? 1'b1 : bits[s - P];
      e_valid[d + 1 + k]  = 1'b1;
      e_sig[d + 1 + k]    = mod_f(b, car[d + k]);
      e_strobe[d + 1 + k] = ((k % S) == 0);
    end
    if (nsup < nbits) e_under[d + S * nsym] = 1'b1;
    e = d + S * nsym;
  endtask

  task automatic check_reset_values();
    chk1("rst_bit_ready", -1, bit_ready, 1'b0);
    chk1("rst_carrier_rst_n", -1, carrier_rst_n, 1'b0);
    chkw("rst_mod_sig", -1, mod_sig, '0);
    chk1("rst_mod_valid", -1, mod_valid, 1'b0);
    chk1("rst_sym_strobe", -1, sym_strobe, 1'b0);
    chk1("rst_busy", -1, busy, 1'b0);
    chk1("rst_underrun", -1, underrun, 1'b0);
  endtask

  task automatic reset_dut();
    bit_valid   = 1'b0;
    bit_data    = 1'b0;
    bit_last    = 1'b0;
    carrier_sig = '0;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk_sig);
    @(negedge clk_sig);
    check_reset_values();
    rst_n = 1'b1;
  endtask

  task automatic run_phase(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk_sig);
      #1;
      bit_valid   = d_valid[c];
      bit_data    = d_data[c];
      bit_last    = d_last[c];
      carrier_sig = car[c];
      @(negedge clk_sig);
      o_valid[c]  = mod_valid;
      o_sig[c]    = mod_sig;
      o_strobe[c] = sym_strobe;
      o_under[c]  = underrun;
      o_crst[c]   = carrier_rst_n;
      chk1("mod_valid", c, mod_valid, e_valid[c]);
      chkw("mod_sig", c, mod_sig, e_sig[c]);
      chk1("sym_strobe", c, sym_strobe, e_strobe[c]);
      chk1("busy", c, busy, e_busy[c]);
      chk1("carrier_rst_n", c, carrier_rst_n, e_crst[c]);
      chk1("bit_ready", c, bit_ready, e_ready[c]);
      chk1("underrun", c, underrun, e_under[c]);
    end
  endtask

  function automatic int first_valid(input int lo, input int hi);
    for (int c = lo; c < hi; c++) if (o_valid[c] === 1'b1) return c;
    return -1;
  endfunction

  initial begin
    int e1;
    int e2;
    int fv;
    int cnt;
    logic [W-1:0] sum;

    // Frame 1,0,1 then a back-to-back frame 0,1 offered in the first idle cycle.
    reset_dut();
    clear_model();
    car[3 + S * P + 40] = 16'h8000;
    plan_frame(0, 3, 3, 8'b0000_0101, e1);
    plan_frame(e1, 2, 2, 8'b0000_0010, e2);
    run_phase(e2 + 6);
    fv = first_valid(0, e1);
    chk_int("first_valid_latency", fv, 4);
    if (fv < 0) fv = 0;
    cnt = 0;
    for (int c = 0; c <= e1; c++) if (o_valid[c] === 1'b1) cnt++;
    chk_int("frame1_valid_count", cnt, 96 + 32 * P);
    cnt = 0;
    for (int c = 0; c <= e1; c++) if (o_strobe[c] === 1'b1) cnt++;
    chk_int("frame1_strobe_count", cnt, 3 + P);
    chk1("strobe_off0", fv + 32 * P, o_strobe[fv + 32 * P], 1'b1);
    chk1("strobe_off32", fv + 32 * P + 32, o_strobe[fv + 32 * P + 32], 1'b1);
    chk1("strobe_off64", fv + 32 * P + 64, o_strobe[fv + 32 * P + 64], 1'b1);
    cnt = 0;
    for (int k = 0; k < 32; k++) begin
      int c;
      c = fv + 32 * P + 32 + k;
      sum = o_sig[c] + car[c - 1];
      if (car[c - 1] == 16'h8000) begin
        if (o_sig[c] == 16'h7FFF) cnt++;
      end else if (sum == '0) begin
        cnt++;
      end
    end
    chk_int("middle_negated_count", cnt, 32);
    chkw("saturation", 4 + 32 * P + 40, o_sig[4 + 32 * P + 40], 16'h7FFF);
    cnt = 0;
    for (int c = 5; c < e2; c++) if (o_crst[c] === 1'b0) cnt++;
    chk_int("b2b_carrier_low_cycles", cnt, 1);
    chk_int("b2b_first_valid_latency", first_valid(e1 + 1, e2 + 6) - e1, 4);

    // Underrun: 2-bit frame, only the first bit is ever offered.
    reset_dut();
    clear_model();
    plan_frame(2, 2, 1, 8'b0000_0001, e1);
    run_phase(e1 + 6);
    fv = first_valid(0, e1 + 6);
    chk_int("underrun_first_valid", fv, 6);
    if (fv < 0) fv = 0;
    chk1("underrun_pulse", fv + 31 + 32 * P, o_under[fv + 31 + 32 * P], 1'b1);
    chk1("underrun_valid_drop", fv + 32 + 32 * P, o_valid[fv + 32 + 32 * P], 1'b0);
    chk1("underrun_carrier_low", fv + 31 + 32 * P, o_crst[fv + 31 + 32 * P], 1'b0);
    cnt = 0;
    for (int c = 0; c < e1 + 6; c++) if (o_under[c] === 1'b1) cnt++;
    chk_int("underrun_pulse_count", cnt, 1);

    // Single-bit frame of 0 (preceded by the preamble when compiled in).
    reset_dut();
    clear_model();
    plan_frame(0, 1, 1, 8'b0000_0000, e1);
    run_phase(e1 + 4);
    cnt = 0;
    for (int c = 0; c < e1 + 4; c++) if (o_valid[c] === 1'b1) cnt++;
    chk_int("one_bit_valid_count", cnt, 32 + 32 * P);

    // Asynchronous reset in the middle of a symbol, then a fresh frame.
    reset_dut();
    clear_model();
    plan_frame(1, 3, 3, 8'b0000_0110, e1);
    run_phase(20);
    @(posedge clk_sig);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    reset_dut();
    clear_model();
    plan_frame(0, 1, 1, 8'b0000_0001, e1);
    run_phase(e1 + 4);
    chk_int("post_reset_first_valid", first_valid(0, e1 + 4), 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
